// File: rtl/mem_core_if.sv
// rtl/mem_core_if.sv - request/ack bus between a master and mem_core
interface mem_core_if;
  logic        readEnable;
  logic        writeEnable;
  logic [11:0] rwAddr;
  logic [7:0]  writeData_in;
  logic [7:0]  readData_out;
  logic        ack;

  modport master (
    output readEnable, writeEnable, rwAddr, writeData_in,
    input  readData_out, ack
  );

  modport slave (
    input  readEnable, writeEnable, rwAddr, writeData_in,
    output readData_out, ack
  );
endinterface

// File: rtl/mem_core.sv
// rtl/mem_core.sv - 4096x8 storage with held-request / one-cycle-ack handshake
// Optional power-up zeroing of storage selected by `define MEM_INIT_CLEAR_EN
module mem_core #(
  parameter int WAIT_STATES = 1
) (
  input logic       clock,
  input logic       reset,
  mem_core_if.slave bus
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

`ifdef MEM_INIT_CLEAR_EN
  typedef enum logic [2:0] {IDLE, WAIT, ACK, RELEASE, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
  logic [11:0] clr_addr;
`else
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      state;
  logic [3:0]  cnt;
  logic [11:0] cap_addr;
  logic [7:0]  cap_data;
  logic        cap_wr;
  logic [7:0]  rdata;
  logic        ack_r;
  logic [7:0]  mem [4096];

  logic        req;
  logic        acc_go;
  logic        acc_wr;
  logic [11:0] acc_addr;
  logic [7:0]  acc_data;

  assign req              = bus.readEnable | bus.writeEnable;
  assign bus.readData_out = rdata;
  assign bus.ack          = ack_r;

  // With no wait states the access happens on the capture edge itself, so the
  // live (being-captured) inputs are the captured values for that one edge.
  always_comb begin
    acc_go   = 1'b0;
    acc_wr   = cap_wr;
    acc_addr = cap_addr;
    acc_data = cap_data;
    if (state == IDLE && WS == 4'd0 && req) begin
      acc_go   = 1'b1;
      acc_wr   = bus.writeEnable;
      acc_addr = bus.rwAddr;
      acc_data = bus.writeData_in;
    end else if (state == WAIT && cnt == 4'd1) begin
      acc_go = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
`ifdef MEM_INIT_CLEAR_EN
      if (state == CLEAR)
        mem[clr_addr] <= 8'h00;
      else
`endif
      if (acc_go && acc_wr)
        mem[acc_addr] <= acc_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET_STATE;
      ack_r <= 1'b0;
      rdata <= 8'h00;
      cnt   <= 4'd0;
`ifdef MEM_INIT_CLEAR_EN
      clr_addr <= 12'd0;
`endif
    end else begin
      ack_r <= 1'b0;
      if (acc_go && !acc_wr)
        rdata <= mem[acc_addr];
      case (state)
        IDLE: begin
          if (req) begin
            cap_addr <= bus.rwAddr;
            cap_data <= bus.writeData_in;
            cap_wr   <= bus.writeEnable;
            if (WS == 4'd0) begin
              ack_r <= 1'b1;
              state <= ACK;
            end else begin
              cnt   <= WS;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            ack_r <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: state <= RELEASE;
        RELEASE: begin
          if (!req)
            state <= IDLE;
        end
`ifdef MEM_INIT_CLEAR_EN
        CLEAR: begin
          clr_addr <= clr_addr + 12'd1;
          if (clr_addr == 12'hFFF)
            state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_core.sv
// tb/tb_mem_core.sv - scoreboard bench for mem_core at WAIT_STATES=1 and 0
module tb_mem_core;
  logic clock;
  logic reset;

  mem_core_if bus0 ();
  mem_core_if bus1 ();

  mem_core #(.WAIT_STATES(1)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  mem_core #(.WAIT_STATES(0)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model [int];
  logic [7:0] exp_rd [2];
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit re, input bit we,
                       input logic [11:0] a, input logic [7:0] d);
    if (w == 0) begin
      bus0.readEnable = re; bus0.writeEnable = we; bus0.rwAddr = a; bus0.writeData_in = d;
    end else begin
      bus1.readEnable = re; bus1.writeEnable = we; bus1.rwAddr = a; bus1.writeData_in = d;
    end
  endtask

  function automatic logic get_ack(input int w);
    return (w == 0) ? bus0.ack : bus1.ack;
  endfunction

  function automatic logic [7:0] get_rd(input int w);
    return (w == 0) ? bus0.readData_out : bus1.readData_out;
  endfunction

  task automatic do_req(input int w, input bit re, input bit we, input logic [11:0] a,
                        input logic [7:0] d, input int hold, input bit scramble);
    int key;
    int n;
    bit got;
    logic [7:0] e;
    key = w * 4096 + int'(a);
    if (we) model[key] = d;
    else if (re) exp_rd[w] = model.exists(key) ? model[key] : 8'h00;
    exp_q.push_back(exp_rd[w]);
    drive(w, re, we, a, d);
    n = 0;
    got = 0;
    while (n < 40 && !got) begin
      @(posedge clock); #1;
      n++;
      if (get_ack(w)) got = 1;
      else if (scramble) drive(w, re, we, a ^ 12'h5A5, d ^ 8'hFF);
    end
    check_eq($sformatf("ack_seen_d%0d", w), 32'(got), 32'd1);
    check_eq($sformatf("latency_d%0d", w), 32'(n), (w == 0) ? 32'd2 : 32'd1);
    e = exp_q.pop_front();
    check_eq($sformatf("rdata_d%0d_a%0h", w, a), 32'(get_rd(w)), 32'(e));
    @(posedge clock); #1;
    check_eq($sformatf("ack_pulse_d%0d", w), 32'(get_ack(w)), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check_eq($sformatf("ack_held_d%0d", w), 32'(get_ack(w)), 32'd0);
    end
    drive(w, 1'b0, 1'b0, a, d);
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  task automatic wait_clear();
`ifdef MEM_INIT_CLEAR_EN
    model.delete();
    repeat (4100) @(posedge clock);
    #1;
`endif
  endtask

  logic [11:0] pool [8];

  initial begin
    int n;
    reset = 1'b1;
    drive(0, 0, 0, 12'h0, 8'h0);
    drive(1, 0, 0, 12'h0, 8'h0);
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_ack_d0", 32'(bus0.ack), 32'd0);
    check_eq("reset_rd_d0", 32'(bus0.readData_out), 32'd0);
    check_eq("reset_ack_d1", 32'(bus1.ack), 32'd0);
    check_eq("reset_rd_d1", 32'(bus1.readData_out), 32'd0);
    reset = 1'b0;

`ifdef MEM_INIT_CLEAR_EN
    drive(0, 1, 0, 12'h000, 8'h00);
    n = 0;
    while (n < 5000 && !bus0.ack) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("clear_latency", 32'(n), 32'd4098);
    drive(0, 0, 0, 12'h000, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    for (int w = 0; w < 2; w++) begin
      do_req(w, 1, 0, 12'h000, 8'h00, 0, 0);
      do_req(w, 1, 0, 12'hFFF, 8'h00, 0, 0);
    end
`endif

    // write/read pair with one wait state
    do_req(0, 0, 1, 12'h123, 8'hA5, 0, 0);
    do_req(0, 1, 0, 12'h123, 8'h00, 0, 0);

    // zero wait states: neighbouring address must survive
    do_req(1, 0, 1, 12'h000, 8'h5A, 0, 0);
    do_req(1, 0, 1, 12'hFFF, 8'h3C, 0, 0);
    do_req(1, 1, 0, 12'hFFF, 8'h00, 0, 0);
    do_req(1, 1, 0, 12'h000, 8'h00, 0, 0);

    // enable held past ack
    do_req(0, 1, 0, 12'h123, 8'h00, 3, 0);
    do_req(1, 1, 0, 12'hFFF, 8'h00, 3, 0);

    // both enables: write wins, read data untouched
    do_req(0, 1, 1, 12'h010, 8'h77, 0, 0);
    do_req(0, 1, 0, 12'h010, 8'h00, 0, 0);
    do_req(1, 1, 1, 12'h010, 8'h77, 0, 0);
    do_req(1, 1, 0, 12'h010, 8'h00, 0, 0);

    // inputs changed after capture must be ignored
    do_req(0, 0, 1, 12'h0F0, 8'hC3, 0, 1);
    do_req(0, 1, 0, 12'h0F0, 8'h00, 0, 1);
    do_req(0, 1, 0, 12'h0F0 ^ 12'h5A5, 8'h00, 0, 0);

    for (int i = 0; i < 8; i++) begin
      pool[i] = 12'($urandom_range(0, 4095));
      for (int w = 0; w < 2; w++)
        do_req(w, 0, 1, pool[i], 8'($urandom), 0, 0);
    end
    for (int i = 0; i < 24; i++) begin
      int w;
      int k;
      w = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_req(w, 0, 1, pool[k], 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      else
        do_req(w, 1, 0, pool[k], 8'h00, int'($urandom_range(0, 2)), 1'($urandom));
    end

    // reset during WAIT of a write aborts it
    do_req(0, 0, 1, 12'h020, 8'h11, 0, 0);
    do_req(0, 1, 0, 12'h123, 8'h00, 0, 0);
    drive(0, 0, 1, 12'h020, 8'hFF);
    @(posedge clock); #1;
    check_eq("abort_wait_ack", 32'(bus0.ack), 32'd0);
    reset = 1'b1;
    drive(0, 0, 0, 12'h020, 8'hFF);
    @(posedge clock); #1;
    check_eq("abort_ack", 32'(bus0.ack), 32'd0);
    check_eq("abort_rd_d0", 32'(bus0.readData_out), 32'd0);
    check_eq("abort_rd_d1", 32'(bus1.readData_out), 32'd0);
    reset = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    @(posedge clock); #1;
    check_eq("abort_no_late_ack", 32'(bus0.ack), 32'd0);
    wait_clear();
    do_req(0, 1, 0, 12'h020, 8'h00, 0, 0);
    do_req(0, 1, 0, 12'h123, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
